// File: rtl/chacha_param_loader.sv
// Assembles the ChaCha20 key, nonce and block counter from a word stream or the TRNG and commits them atomically.
// Define TRNG_REPCHECK_EN to discard repeated TRNG words and abort on a third identical word.
//
// state     | meaning
// IDLE      | waiting for start; ctr_inc honoured here
// ACQ_KEY   | collecting key words
// ACQ_NONCE | collecting nonce words
// ACQ_CTR   | collecting counter words
// COMMIT    | copy shadow fields to outputs, pulse done
module chacha_param_loader #(
    parameter int WORD_W         = 32,
    parameter int KEY_WORDS      = 8,
    parameter int NONCE_WORDS    = 3,
    parameter int CTR_WORDS      = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          reuse_key,
    input  logic [2:0]                    src_stream,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    input  logic                          chunk_valid,
    input  logic [1:0]                    chunk_type,
    input  logic [WORD_W-1:0]             chunk_data,
    output logic                          chunk_ready,
    output logic [1:0]                    request_type,
    output logic [3:0]                    chunk_index,
    output logic                          trng_request,
    input  logic                          trng_ready,
    input  logic [WORD_W-1:0]             trng_data,
    input  logic                          ctr_inc,
    output logic [KEY_WORDS*WORD_W-1:0]   key_out,
    output logic [NONCE_WORDS*WORD_W-1:0] nonce_out,
    output logic [CTR_WORDS*WORD_W-1:0]   counter_out,
    output logic                          params_valid,
    output logic                          ctr_wrapped
);

    localparam int KEY_W   = KEY_WORDS * WORD_W;
    localparam int NONCE_W = NONCE_WORDS * WORD_W;
    localparam int CTR_W   = CTR_WORDS * WORD_W;
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] KEY_LAST   = 4'(KEY_WORDS - 1);
    localparam logic [3:0] NONCE_LAST = 4'(NONCE_WORDS - 1);
    localparam logic [3:0] CTR_LAST   = 4'(CTR_WORDS - 1);

    typedef enum logic [2:0] {IDLE, ACQ_KEY, ACQ_NONCE, ACQ_CTR, COMMIT} state_t;

    state_t              state;
    state_t              next_state;
    logic [3:0]          word_cnt;
    logic [3:0]          last_idx;
    logic [TO_W-1:0]     idle_cnt;
    logic [2:0]          src_q;
    logic                skip_key;
    logic [KEY_W-1:0]    key_sh;
    logic [NONCE_W-1:0]  nonce_sh;
    logic [CTR_W-1:0]    ctr_sh;
    logic [1:0]          next_code;
    logic                in_acq;
    logic                src_cur;
    logic                stream_hit;
    logic                stream_bad;
    logic                trng_hit;
    logic                rep_fail;
    logic                accept;
    logic                abort;
    logic [WORD_W-1:0]   wdata;

    always_comb begin
        in_acq     = 1'b0;
        src_cur    = 1'b0;
        last_idx   = 4'd0;
        next_state = IDLE;
        next_code  = request_type;
        case (state)
            ACQ_KEY: begin
                in_acq     = 1'b1;
                src_cur    = src_q[0];
                last_idx   = KEY_LAST;
                next_state = ACQ_NONCE;
                next_code  = 2'b01;
            end
            ACQ_NONCE: begin
                in_acq     = 1'b1;
                src_cur    = src_q[1];
                last_idx   = NONCE_LAST;
                next_state = ACQ_CTR;
                next_code  = 2'b10;
            end
            ACQ_CTR: begin
                in_acq     = 1'b1;
                src_cur    = src_q[2];
                last_idx   = CTR_LAST;
                next_state = COMMIT;
            end
            default: ;
        endcase
    end

    assign chunk_ready  = in_acq && src_cur;
    assign trng_request = in_acq && !src_cur;
    assign chunk_index  = word_cnt;
    assign stream_hit   = chunk_ready && chunk_valid && (chunk_type == request_type);
    assign stream_bad   = chunk_ready && chunk_valid && (chunk_type != request_type);
    assign wdata        = src_cur ? chunk_data : trng_data;

`ifdef TRNG_REPCHECK_EN
    logic [WORD_W-1:0] prev_word;
    logic              prev_vld;
    logic              rep_seen;
    logic              trng_dup;

    // History spans all TRNG fields of one acquisition; one repeat is tolerated.
    assign trng_dup = prev_vld && (trng_data == prev_word);
    assign trng_hit = trng_request && trng_ready && !trng_dup;
    assign rep_fail = trng_request && trng_ready && trng_dup && rep_seen;
`else
    assign trng_hit = trng_request && trng_ready;
    assign rep_fail = 1'b0;
`endif

    assign accept = stream_hit || trng_hit;
    assign abort  = stream_bad || rep_fail || (in_acq && !accept && idle_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            params_valid <= 1'b0;
            ctr_wrapped  <= 1'b0;
            request_type <= 2'b00;
            word_cnt     <= 4'd0;
            idle_cnt     <= '0;
            src_q        <= 3'b000;
            skip_key     <= 1'b0;
            key_sh       <= '0;
            nonce_sh     <= '0;
            ctr_sh       <= '0;
            key_out      <= '0;
            nonce_out    <= '0;
            counter_out  <= '0;
`ifdef TRNG_REPCHECK_EN
            prev_word    <= '0;
            prev_vld     <= 1'b0;
            rep_seen     <= 1'b0;
`endif
        end else begin
            done        <= 1'b0;
            error       <= 1'b0;
            ctr_wrapped <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy         <= 1'b1;
                        params_valid <= 1'b0;
                        word_cnt     <= 4'd0;
                        idle_cnt     <= TO_LOAD;
                        src_q        <= src_stream;
`ifdef TRNG_REPCHECK_EN
                        prev_vld     <= 1'b0;
                        rep_seen     <= 1'b0;
`endif
                        if (reuse_key && params_valid) begin
                            skip_key     <= 1'b1;
                            state        <= ACQ_NONCE;
                            request_type <= 2'b01;
                        end else begin
                            skip_key     <= 1'b0;
                            state        <= ACQ_KEY;
                            request_type <= 2'b00;
                        end
                    end else if (ctr_inc && params_valid) begin
                        counter_out <= counter_out + CTR_W'(1);
                        ctr_wrapped <= (counter_out == '1);
                    end
                end
                ACQ_KEY, ACQ_NONCE, ACQ_CTR: begin
                    if (abort) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        word_cnt <= 4'd0;
                    end else if (accept) begin
                        idle_cnt <= TO_LOAD;
                        for (int i = 0; i < KEY_WORDS; i++)
                            if (state == ACQ_KEY && word_cnt == 4'(i))
                                key_sh[i*WORD_W +: WORD_W] <= wdata;
                        for (int i = 0; i < NONCE_WORDS; i++)
                            if (state == ACQ_NONCE && word_cnt == 4'(i))
                                nonce_sh[i*WORD_W +: WORD_W] <= wdata;
                        for (int i = 0; i < CTR_WORDS; i++)
                            if (state == ACQ_CTR && word_cnt == 4'(i))
                                ctr_sh[i*WORD_W +: WORD_W] <= wdata;
                        if (word_cnt == last_idx) begin
                            word_cnt     <= 4'd0;
                            state        <= next_state;
                            request_type <= next_code;
                        end else begin
                            word_cnt <= word_cnt + 4'd1;
                        end
`ifdef TRNG_REPCHECK_EN
                        if (!src_cur) begin
                            prev_word <= trng_data;
                            prev_vld  <= 1'b1;
                            rep_seen  <= 1'b0;
                        end
`endif
                    end else begin
                        idle_cnt <= idle_cnt - TO_W'(1);
`ifdef TRNG_REPCHECK_EN
                        if (trng_request && trng_ready)
                            rep_seen <= 1'b1;
`endif
                    end
                end
                COMMIT: begin
                    if (!skip_key)
                        key_out <= key_sh;
                    nonce_out    <= nonce_sh;
                    counter_out  <= ctr_sh;
                    done         <= 1'b1;
                    params_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
